// File: rtl/hdmi_pkg.sv
// Shared encodings for the HDMI period tracker: FSM states, period codes,
// guard-band characters and preamble CTL codes.
package hdmi_pkg;

  typedef enum logic [2:0] {
    ST_CTRL,
    ST_VPRE,
    ST_DPRE,
    ST_VGUARD,
    ST_VIDEO,
    ST_DGUARD_L,
    ST_ISLAND,
    ST_DGUARD_T
  } state_t;

  typedef enum logic [1:0] {
    PER_CTRL   = 2'd0,
    PER_VIDEO  = 2'd1,
    PER_ISLAND = 2'd2,
    PER_GUARD  = 2'd3
  } period_t;

  localparam logic [9:0] GB_2CC = 10'h2CC;
  localparam logic [9:0] GB_133 = 10'h133;

  localparam logic [3:0] CTL_VID_PRE = 4'b0001;
  localparam logic [3:0] CTL_ISL_PRE = 4'b0101;

  // raw = {ch2,ch1,ch0}
  function automatic logic is_vid_guard(input logic [29:0] raw);
    return (raw[9:0] == GB_2CC) && (raw[19:10] == GB_133) && (raw[29:20] == GB_2CC);
  endfunction

  // raw_hi = {ch2,ch1}; ch0 carries TERC4 data in island guards
  function automatic logic is_isl_guard(input logic [19:0] raw_hi);
    return (raw_hi[9:0] == GB_133) && (raw_hi[19:10] == GB_133);
  endfunction

endpackage

// File: rtl/hdmi_preamble_det.sv
// Consecutive-CTL preamble counter; flags the character that completes (or
// extends) a full video or data-island preamble.
module hdmi_preamble_det
  import hdmi_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_en,
  input  logic       i_valid,
  input  logic [3:0] i_ctl,
  output logic       o_vid_hit,
  output logic       o_isl_hit
);

  localparam int unsigned CW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [CW-1:0] LP_LEN = CW'(PREAMBLE_LEN);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next;
  logic          r_isl;
  logic          w_vid;
  logic          w_isl;
  logic          w_same;

  assign w_vid  = i_en && i_valid && (i_ctl == CTL_VID_PRE);
  assign w_isl  = i_en && i_valid && (i_ctl == CTL_ISL_PRE);
  assign w_same = (r_cnt != '0) && (r_isl == w_isl);

  // A switch between the two preamble codes restarts the run at one.
  always_comb begin
    w_next = '0;
    if (w_vid || w_isl) begin
      if (!w_same)
        w_next = CW'(1);
      else if (r_cnt == LP_LEN)
        w_next = r_cnt;
      else
        w_next = r_cnt + CW'(1);
    end
  end

  assign o_vid_hit = w_vid && (w_next == LP_LEN);
  assign o_isl_hit = w_isl && (w_next == LP_LEN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_isl <= 1'b0;
    end else begin
      r_cnt <= w_next;
      if (w_vid || w_isl)
        r_isl <= w_isl;
    end
  end

endmodule

// File: rtl/hdmi_period_tracker.sv
// Classifies aligned TMDS/TERC4 characters into HDMI control/video/island periods.
// Optional active-size statistics are built when HDMI_PERIOD_STATS_EN is defined.
module hdmi_period_tracker
  import hdmi_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned MAX_PACKETS  = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] raw,
  input  logic [2:0]  data_valid,
  input  logic [2:0]  sync_valid,
  input  logic [2:0]  ctrl_valid,
  input  logic [5:0]  sync,
  input  logic [11:0] ctrl,
  input  logic [23:0] data,
  output logic [1:0]  period,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        pkt_valid,
  output logic        pkt_start,
  output logic [4:0]  pkt_index,
  output logic [11:0] pkt_nibbles,
  output logic        error,
  output logic [11:0] h_active,
  output logic [11:0] v_active
);

  localparam logic [4:0] LP_MAXP = 5'(MAX_PACKETS);

  state_t      r_state;
  period_t     r_period;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_de;
  logic [23:0] r_rgb;
  logic        r_pkt_valid;
  logic        r_pkt_start;
  logic [4:0]  r_pkt_index;
  logic [11:0] r_pkt_nibbles;
  logic        r_error;
  logic        r_stray;
  logic [4:0]  r_cnt;
  logic [4:0]  r_idx;

  logic w_pixel;
  logic w_terc4;
  logic w_vguard;
  logic w_iguard;
  logic w_iguard_l;
  logic w_video_end;
  logic w_ctrl_ctx;
  logic w_vid_hit;
  logic w_isl_hit;

  assign w_pixel     = &data_valid;
  assign w_terc4     = &ctrl_valid;
  assign w_vguard    = is_vid_guard(raw);
  assign w_iguard    = is_isl_guard(raw[29:10]);
  assign w_iguard_l  = w_iguard && ctrl_valid[0];
  assign w_video_end = (r_state == ST_VIDEO) && !w_pixel;
  // The character ending a video period is handled as a control character.
  assign w_ctrl_ctx  = (r_state == ST_CTRL) || (r_state == ST_VPRE) ||
                       (r_state == ST_DPRE) || w_video_end;

  hdmi_preamble_det #(
    .PREAMBLE_LEN(PREAMBLE_LEN)
  ) u_pre (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_en     (w_ctrl_ctx),
    .i_valid  (&sync_valid),
    .i_ctl    (sync[5:2]),
    .o_vid_hit(w_vid_hit),
    .o_isl_hit(w_isl_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_CTRL;
      r_period      <= PER_CTRL;
      r_hsync       <= 1'b0;
      r_vsync       <= 1'b0;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_pkt_valid   <= 1'b0;
      r_pkt_start   <= 1'b0;
      r_pkt_index   <= '0;
      r_pkt_nibbles <= '0;
      r_error       <= 1'b0;
      r_stray       <= 1'b0;
      r_cnt         <= '0;
      r_idx         <= '0;
    end else begin
      r_error     <= 1'b0;
      r_de        <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_pkt_start <= 1'b0;
      r_period    <= PER_CTRL;
      r_stray     <= 1'b0;
      if (w_ctrl_ctx) begin
        if (sync_valid[0] && !w_vguard)
          {r_vsync, r_hsync} <= sync[1:0];
        if (w_vid_hit) begin
          r_state <= ST_VPRE;
        end else if (w_isl_hit) begin
          r_state <= ST_DPRE;
        end else if ((r_state == ST_VPRE) && w_vguard) begin
          r_state  <= ST_VGUARD;
          r_period <= PER_GUARD;
        end else if ((r_state == ST_DPRE) && w_iguard_l) begin
          r_state            <= ST_DGUARD_L;
          r_period           <= PER_GUARD;
          {r_vsync, r_hsync} <= ctrl[1:0];
        end else begin
          r_state <= ST_CTRL;
          if ((r_state == ST_VPRE) || (r_state == ST_DPRE)) begin
            r_error <= 1'b1;
          end else if (w_vguard || w_iguard) begin
            // An unarmed guard band is reported once, not per character.
            r_stray <= 1'b1;
            r_error <= !r_stray;
          end
        end
      end else begin
        case (r_state)
          ST_VGUARD: begin
            if (w_vguard) begin
              r_state  <= ST_VIDEO;
              r_period <= PER_GUARD;
            end else begin
              r_state <= ST_CTRL;
              r_error <= 1'b1;
              if (sync_valid[0]) {r_vsync, r_hsync} <= sync[1:0];
            end
          end
          ST_DGUARD_L: begin
            if (w_iguard_l) begin
              r_state            <= ST_ISLAND;
              r_period           <= PER_GUARD;
              {r_vsync, r_hsync} <= ctrl[1:0];
              r_cnt              <= '0;
              r_idx              <= '0;
            end else begin
              r_state <= ST_CTRL;
              r_error <= 1'b1;
              if (sync_valid[0]) {r_vsync, r_hsync} <= sync[1:0];
            end
          end
          ST_VIDEO: begin
            r_de     <= 1'b1;
            r_rgb    <= data;
            r_period <= PER_VIDEO;
          end
          ST_ISLAND: begin
            if ((r_cnt == '0) && (r_idx != '0) && w_iguard) begin
              r_state  <= ST_DGUARD_T;
              r_period <= PER_GUARD;
              if (ctrl_valid[0]) {r_vsync, r_hsync} <= ctrl[1:0];
            end else if (!w_terc4 || ((r_cnt == '0) && (r_idx >= LP_MAXP))) begin
              r_state <= ST_CTRL;
              r_error <= 1'b1;
              if (sync_valid[0]) {r_vsync, r_hsync} <= sync[1:0];
            end else begin
              r_period           <= PER_ISLAND;
              r_pkt_valid        <= 1'b1;
              r_pkt_start        <= (r_cnt == '0);
              r_pkt_index        <= r_idx;
              r_pkt_nibbles      <= ctrl;
              {r_vsync, r_hsync} <= ctrl[1:0];
              r_cnt              <= r_cnt + 5'd1;
              if (&r_cnt)
                r_idx <= r_idx + 5'd1;
            end
          end
          ST_DGUARD_T: begin
            r_state  <= ST_CTRL;
            r_period <= PER_GUARD;
            if (ctrl_valid[0]) {r_vsync, r_hsync} <= ctrl[1:0];
          end
          default: r_state <= ST_CTRL;
        endcase
      end
    end
  end

  assign period      = r_period;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb         = r_rgb;
  assign pkt_valid   = r_pkt_valid;
  assign pkt_start   = r_pkt_start;
  assign pkt_index   = r_pkt_index;
  assign pkt_nibbles = r_pkt_nibbles;
  assign error       = r_error;

`ifdef HDMI_PERIOD_STATS_EN
  logic [11:0] r_hcnt;
  logic [11:0] r_vcnt;
  logic [11:0] r_h_active;
  logic [11:0] r_v_active;
  logic        r_vsync_d;
  logic        w_vrise;

  assign w_vrise = r_vsync && !r_vsync_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_h_active <= '0;
      r_v_active <= '0;
      r_vsync_d  <= 1'b0;
    end else begin
      r_vsync_d <= r_vsync;
      if (w_video_end) begin
        r_h_active <= r_hcnt;
        r_hcnt     <= '0;
      end else if ((r_state == ST_VIDEO) && (r_hcnt != '1)) begin
        r_hcnt <= r_hcnt + 12'd1;
      end
      if (w_vrise) begin
        r_v_active <= r_vcnt;
        r_vcnt     <= w_video_end ? 12'd1 : 12'd0;
      end else if (w_video_end && (r_vcnt != '1)) begin
        r_vcnt <= r_vcnt + 12'd1;
      end
    end
  end

  assign h_active = r_h_active;
  assign v_active = r_v_active;
`else
  assign h_active = '0;
  assign v_active = '0;
`endif

endmodule

// File: tb/tb_hdmi_period_tracker.sv
// Scoreboard bench for hdmi_period_tracker: stimulus queues expected de/packet/error
// events, a monitor pops them whenever the DUT presents one.
module tb_hdmi_period_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] raw;
  logic [2:0]  data_valid, sync_valid, ctrl_valid;
  logic [5:0]  sync;
  logic [11:0] ctrl;
  logic [23:0] data;
  logic [1:0]  period;
  logic        hsync, vsync, de, pkt_valid, pkt_start, error;
  logic [23:0] rgb;
  logic [4:0]  pkt_index;
  logic [11:0] pkt_nibbles, h_active, v_active;

  always #5 clk = ~clk;

  hdmi_period_tracker #(
    .PREAMBLE_LEN(8),
    .MAX_PACKETS (18)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .raw        (raw),
    .data_valid (data_valid),
    .sync_valid (sync_valid),
    .ctrl_valid (ctrl_valid),
    .sync       (sync),
    .ctrl       (ctrl),
    .data       (data),
    .period     (period),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .rgb        (rgb),
    .pkt_valid  (pkt_valid),
    .pkt_start  (pkt_start),
    .pkt_index  (pkt_index),
    .pkt_nibbles(pkt_nibbles),
    .error      (error),
    .h_active   (h_active),
    .v_active   (v_active)
  );

  // kind: 0 = pixel (de), 1 = island character, 2 = error strobe
  typedef struct {
    int          kind;
    logic [23:0] val;
    logic        st;
    logic [4:0]  idx;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [23:0] pix(input int i);
    return 24'(i * 32'h00010307 + 32'h00123456);
  endfunction

  task automatic set_idle();
    raw = '0; data_valid = '0; sync_valid = '0; ctrl_valid = '0;
    sync = '0; ctrl = '0; data = '0;
  endtask

  task automatic ctl_char(input logic [3:0] code, input logic [1:0] vh);
    set_idle(); sync_valid = 3'b111; sync = {code, vh}; raw = {3{10'h354}};
    @(negedge clk);
  endtask

  task automatic vguard();
    set_idle(); raw = {10'h2CC, 10'h133, 10'h2CC};
    @(negedge clk);
  endtask

  task automatic iguard();
    set_idle(); raw = {10'h133, 10'h133, 10'h2A3}; ctrl_valid = 3'b001; ctrl = 12'h001;
    @(negedge clk);
  endtask

  task automatic pixel(input logic [23:0] d, input bit expect_de);
    set_idle(); data_valid = 3'b111; data = d; raw = {3{10'h0F0}};
    if (expect_de) q.push_back('{0, d, 1'b0, 5'd0});
    @(negedge clk);
  endtask

  task automatic terc(input logic [11:0] n, input bit st, input logic [4:0] idx, input bit push);
    set_idle(); ctrl_valid = 3'b111; ctrl = n; raw = {3{10'h29C}};
    if (push) q.push_back('{1, {12'h000, n}, st, idx});
    @(negedge clk);
  endtask

  task automatic bad_char();
    set_idle(); ctrl_valid = 3'b001; raw = {3{10'h29C}};
    @(negedge clk);
  endtask

  task automatic expect_err();
    q.push_back('{2, 24'h0, 1'b0, 5'd0});
  endtask

  task automatic island_intro();
    for (int i = 0; i < 8; i++) ctl_char(4'b0101, 2'b00);
    iguard();
    iguard();
  endtask

  // Monitor / scoreboard
  initial begin
    exp_t e;
    int   ak;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && (de || pkt_valid || error)) begin
        ak = error ? 2 : (pkt_valid ? 1 : 0);
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_event: de=%0b pkt_valid=%0b error=%0b, none expected at %0t",
                   de, pkt_valid, error, $time);
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(ak), 32'(e.kind));
          if (e.kind == 0) begin
            chk("rgb", 32'(rgb), 32'(e.val));
            chk("video_period", 32'(period), 32'd1);
          end else if (e.kind == 1) begin
            chk("pkt_nibbles", 32'(pkt_nibbles), 32'(e.val[11:0]));
            chk("pkt_start", 32'(pkt_start), 32'(e.st));
            chk("pkt_index", 32'(pkt_index), 32'(e.idx));
            chk("island_period", 32'(period), 32'd2);
          end else begin
            chk("error_period", 32'(period), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    logic [11:0] exp_h;
`ifdef HDMI_PERIOD_STATS_EN
    exp_h = 12'd640;
`else
    exp_h = 12'd0;
`endif
    set_idle();
    reset_n = 1'b0;
    #13;
    chk("rst_period", 32'(period), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_pkt", 32'({pkt_valid, pkt_start, pkt_index, pkt_nibbles}), 0);
    chk("rst_sync", 32'({vsync, hsync}), 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_stats", 32'({h_active, v_active}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Video period: 8 preamble, 2 guards, 640 pixels, control
    for (int i = 0; i < 8; i++) ctl_char(4'b0001, 2'b10);
    chk("vpre_period", 32'(period), 0);
    chk("vpre_vsync", 32'({vsync, hsync}), 32'b10);
    vguard();
    chk("vguard1_period", 32'(period), 3);
    vguard();
    chk("vguard2_period", 32'(period), 3);
    for (int i = 0; i < 640; i++) begin
      pixel(pix(i), 1'b1);
      if (i == 0) chk("video_sync_held", 32'({vsync, hsync}), 32'b10);
    end
    ctl_char(4'b0000, 2'b00);
    chk("video_end_period", 32'(period), 0);
    chk("video_end_de", 32'(de), 0);
    chk("h_active", 32'(h_active), 32'(exp_h));

    // Broken preamble: 7 + unrelated control, then guards
    for (int i = 0; i < 7; i++) ctl_char(4'b0001, 2'b00);
    ctl_char(4'b0000, 2'b00);
    expect_err();
    vguard();
    chk("stray_g1_period", 32'(period), 0);
    vguard();
    chk("stray_g2_period", 32'(period), 0);
    pixel(pix(7), 1'b0);
    chk("stray_no_de", 32'(de), 0);
    chk("stray_no_video", 32'(period), 0);

    // Island: 2 packets then trailing guards
    island_intro();
    chk("island_lead_period", 32'(period), 3);
    for (int i = 0; i < 64; i++) begin
      terc({10'(i), 2'b01}, (i % 32) == 0, 5'(i / 32), 1'b1);
      if (i == 0) chk("island_sync", 32'({vsync, hsync}), 32'b01);
    end
    iguard();
    chk("trail_g1_period", 32'(period), 3);
    iguard();
    chk("trail_g2_period", 32'(period), 3);
    ctl_char(4'b0000, 2'b00);
    chk("island_end_period", 32'(period), 0);

    // Island with a non-TERC4 character at index 10
    island_intro();
    for (int i = 0; i < 10; i++) terc({10'(i + 100), 2'b01}, i == 0, 5'd0, 1'b1);
    expect_err();
    bad_char();
    ctl_char(4'b0000, 2'b00);
    chk("bad_terc_next_period", 32'(period), 0);
    chk("bad_terc_error_once", 32'(error), 0);

    // Packet limit: 18 packets accepted, 19th start errors
    island_intro();
    for (int i = 0; i < 18 * 32; i++) terc({10'(i), 2'b00}, (i % 32) == 0, 5'(i / 32), 1'b1);
    expect_err();
    terc(12'hABC, 1'b1, 5'd18, 1'b0);
    chk("maxpkt_period", 32'(period), 0);
    ctl_char(4'b0000, 2'b00);
    chk("maxpkt_after_period", 32'(period), 0);

    // Reset during video
    for (int i = 0; i < 8; i++) ctl_char(4'b0001, 2'b11);
    vguard();
    vguard();
    for (int i = 0; i < 5; i++) pixel(pix(i + 1000), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_de", 32'(de), 0);
    chk("async_rst_period", 32'(period), 0);
    chk("async_rst_rgb_sync", 32'({rgb, vsync, hsync}), 0);
    set_idle();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) ctl_char(4'b0001, 2'b00);
    expect_err();
    vguard();
    vguard();
    pixel(pix(3), 1'b0);
    chk("post_rst_short_pre", 32'(period), 0);
    for (int i = 0; i < 8; i++) ctl_char(4'b0001, 2'b00);
    vguard();
    vguard();
    for (int i = 0; i < 3; i++) pixel(pix(i + 2000), 1'b1);
    ctl_char(4'b0000, 2'b00);
    chk("post_rst_video_end", 32'(period), 0);

    set_idle();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
